// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshakes and SRAM s1 pins of the capture SRAM arbiter.
interface sram_port_arbiter_if #(parameter int ADDR_W = 18, parameter int DATA_W = 32);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_wdata;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              arb_busy;
    logic [ADDR_W-1:0] s1_Addr;
    logic [DATA_W-1:0] s1_WD;
    logic [DATA_W-1:0] s1_RD;
    logic              s1_OE;
    logic              s1_WE;
    modport slave (
        input  wr_req, wr_addr, wr_wdata, rd_req, rd_addr, s1_RD,
        output wr_ack, rd_data, rd_valid, arb_busy, s1_Addr, s1_WD, s1_OE, s1_WE
    );
    modport master (
        output wr_req, wr_addr, wr_wdata, rd_req, rd_addr, s1_RD,
        input  wr_ack, rd_data, rd_valid, arb_busy, s1_Addr, s1_WD, s1_OE, s1_WE
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares SRAM port s1 between a priority writer and a reader.
// Define SRAM_ARB_FAIRNESS_EN to force a read after MAX_WR_BURST writes while a read waits.
module sram_port_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int MAX_WR_BURST = 8
) (
    input logic                clk,
    input logic                reset_n,
    sram_port_arbiter_if.slave bus
);
    localparam logic [3:0] LAT_M1 = 4'((RD_LAT < 1 ? 1 : RD_LAT) - 1);
    typedef enum logic [1:0] {IDLE, WRITE, WREC, READ} state_t;
    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wd_d, rdata_d;
    logic              oe_d, we_d, ack_d, valid_d, rd_ok, grant_wr, grant_rd;
    // the rd_valid cycle still shows the completed request, so no read is re-granted in it
    assign rd_ok = bus.rd_req && !bus.rd_valid;
`ifdef SRAM_ARB_FAIRNESS_EN
    logic [3:0] fair, fair_d;
    assign grant_wr = bus.wr_req && !(rd_ok && fair == 4'(MAX_WR_BURST));
    assign fair_d   = state != IDLE ? fair : (rd_ok && grant_wr) ? fair + 4'd1 : 4'd0;
`else
    assign grant_wr = bus.wr_req;
`endif
    assign grant_rd     = !grant_wr && rd_ok;
    assign bus.arb_busy = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.s1_Addr  <= '1;
            bus.s1_WD    <= '0;
            bus.s1_OE    <= 1'b1;
            bus.s1_WE    <= 1'b1;
            bus.wr_ack   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
`ifdef SRAM_ARB_FAIRNESS_EN
            fair         <= '0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bus.s1_Addr  <= addr_d;
            bus.s1_WD    <= wd_d;
            bus.s1_OE    <= oe_d;
            bus.s1_WE    <= we_d;
            bus.wr_ack   <= ack_d;
            bus.rd_valid <= valid_d;
            bus.rd_data  <= rdata_d;
`ifdef SRAM_ARB_FAIRNESS_EN
            fair         <= fair_d;
`endif
        end
    end
    always_comb begin
        state_d = state == IDLE  ? (grant_wr ? WRITE : grant_rd ? READ : IDLE) :
                  state == WRITE ? WREC :
                  (state == READ && cnt != 4'd0) ? READ : IDLE;
    end
    always_comb begin
        cnt_d   = cnt;
        addr_d  = bus.s1_Addr;
        wd_d    = bus.s1_WD;
        oe_d    = bus.s1_OE;
        we_d    = 1'b1;
        ack_d   = 1'b0;
        valid_d = 1'b0;
        rdata_d = bus.rd_data;
        case (state)
            IDLE:
                if (grant_wr) begin
                    addr_d = bus.wr_addr;
                    wd_d   = bus.wr_wdata;
                    we_d   = 1'b0;
                    ack_d  = 1'b1;
                end else if (grant_rd) begin
                    addr_d = bus.rd_addr;
                    oe_d   = 1'b0;
                    cnt_d  = LAT_M1;
                end
            READ:
                if (cnt != 4'd0) cnt_d = cnt - 4'd1;
                else begin
                    rdata_d = bus.s1_RD;
                    valid_d = 1'b1;
                    oe_d    = 1'b1;
                end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks on two arbiters (RD_LAT=1 and RD_LAT=3) sharing clock and reset.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    sram_port_arbiter_if #(.ADDR_W(18), .DATA_W(32)) a ();
    sram_port_arbiter_if #(.ADDR_W(18), .DATA_W(32)) b ();
    sram_port_arbiter #(.ADDR_W(18), .DATA_W(32), .RD_LAT(1), .MAX_WR_BURST(8)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a));
    sram_port_arbiter #(.ADDR_W(18), .DATA_W(32), .RD_LAT(3), .MAX_WR_BURST(8)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b));
    // SRAM model: each word reads back as DEADBEEF xor its address
    assign a.s1_RD = 32'hDEAD_BEEF ^ 32'(a.s1_Addr);
    assign b.s1_RD = 32'hDEAD_BEEF ^ 32'(b.s1_Addr);
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("no_overlap_a", 64'(a.s1_OE | a.s1_WE), 64'd1);
        chk("no_overlap_b", 64'(b.s1_OE | b.s1_WE), 64'd1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_addr"}, 64'(a.s1_Addr), 64'h3ffff);
        chk({tag, "_wd"}, 64'(a.s1_WD), 64'd0);
        chk({tag, "_strobes"}, 64'({a.s1_OE, a.s1_WE}), 64'd3);
        chk({tag, "_ack_valid_busy"}, 64'({a.wr_ack, a.rd_valid, a.arb_busy}), 64'd0);
        chk({tag, "_rdata"}, 64'(a.rd_data), 64'd0);
    endtask

    initial begin
        int acks, valids, first_rd, n, cyc, last;
        logic upd;
        {a.wr_req, a.wr_addr, a.wr_wdata, a.rd_req, a.rd_addr} = '0;
        {b.wr_req, b.wr_addr, b.wr_wdata, b.rd_req, b.rd_addr} = '0;
        tick();
        chk_reset_a("reset");
        reset_n = 1'b1;
        tick();
        // single write
        a.wr_req = 1'b1; a.wr_addr = 18'h00010; a.wr_wdata = 32'hA5A5_1234;
        tick();
        chk("wr_we_low", 64'(a.s1_WE), 64'd0);
        chk("wr_addr", 64'(a.s1_Addr), 64'h10);
        chk("wr_data", 64'(a.s1_WD), 64'hA5A5_1234);
        chk("wr_ack_busy", 64'({a.wr_ack, a.arb_busy}), 64'd3);
        a.wr_req = 1'b0;
        tick();
        chk("wrec_we_ack", 64'({a.s1_WE, a.wr_ack}), 64'd2);
        chk("wrec_hold", 64'({a.s1_Addr, a.s1_WD}), {14'h0, 18'h10, 32'hA5A5_1234});
        chk("wrec_busy", 64'(a.arb_busy), 64'd1);
        tick();
        chk("wr_idle", 64'({a.arb_busy, a.s1_WE}), 64'd1);
        // read, RD_LAT=1
        a.rd_req = 1'b1; a.rd_addr = 18'h0;
        tick();
        chk("rd1_oe_low", 64'({a.s1_OE, a.rd_valid, a.arb_busy}), 64'd1);
        tick();
        chk("rd1_valid", 64'({a.s1_OE, a.rd_valid, a.arb_busy}), 64'd6);
        chk("rd1_data", 64'(a.rd_data), 64'hDEAD_BEEF);
        a.rd_req = 1'b0;
        tick();
        chk("rd1_pulse_end", 64'(a.rd_valid), 64'd0);
        chk("rd1_data_held", 64'(a.rd_data), 64'hDEAD_BEEF);
        // read, RD_LAT=3
        b.rd_req = 1'b1; b.rd_addr = 18'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd3_oe_low", 64'({b.s1_OE, b.rd_valid}), 64'd0);
        end
        tick();
        chk("rd3_valid", 64'({b.s1_OE, b.rd_valid}), 64'd3);
        chk("rd3_data", 64'(b.rd_data), 64'hDEAD_BEEF);
        b.rd_req = 1'b0;
        tick();
        chk("rd3_pulse_end", 64'(b.rd_valid), 64'd0);
        // simultaneous requests: write first
        a.wr_req = 1'b1; a.wr_addr = 18'h20; a.wr_wdata = 32'h1111_2222;
        a.rd_req = 1'b1; a.rd_addr = 18'h5;
        tick();
        chk("sim_write_first", 64'({a.wr_ack, a.s1_WE, a.s1_OE}), 64'd5);
        a.wr_req = 1'b0;
        tick();
        chk("sim_wrec", 64'({a.s1_WE, a.s1_OE}), 64'd3);
        tick();
        chk("sim_idle", 64'(a.arb_busy), 64'd0);
        tick();
        chk("sim_read", 64'({a.s1_OE, a.s1_Addr}), {45'h0, 1'b0, 18'h5});
        tick();
        chk("sim_valid", 64'(a.rd_valid), 64'd1);
        chk("sim_data", 64'(a.rd_data), 64'hDEAD_BEEA);
        a.rd_req = 1'b0;
        tick();
        // continuous writes with a pending read
        acks = 0; valids = 0; first_rd = 99;
        a.wr_req = 1'b1; a.wr_addr = 18'h40; a.rd_req = 1'b1; a.rd_addr = 18'h7;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (a.wr_ack) acks++;
            if (!a.s1_OE && first_rd == 99) first_rd = acks;
            if (a.rd_valid) begin
                valids++;
                chk("burst_rd_data", 64'(a.rd_data), 64'hDEAD_BEE8);
                a.rd_req = 1'b0;
            end
        end
        a.wr_req = 1'b0; a.rd_req = 1'b0;
        chk("burst_acks", 64'(acks), 64'd50);
`ifdef SRAM_ARB_FAIRNESS_EN
        chk("burst_first_rd", 64'(first_rd), 64'd8);
        chk("burst_valids", 64'(valids), 64'd1);
`else
        chk("burst_first_rd", 64'(first_rd), 64'd99);
        chk("burst_valids", 64'(valids), 64'd0);
`endif
        tick();
        tick();
        // reset during WRITE
        a.wr_req = 1'b1; a.wr_addr = 18'h33; a.wr_wdata = 32'hCAFE_0001;
        tick();
        chk("rstw_pre", 64'({a.wr_ack, a.s1_WE}), 64'd2);
        reset_n = 1'b0;
        #1;
        chk_reset_a("rstw");
        a.wr_req = 1'b0;
        tick();
        chk("rstw_no_ack", 64'({a.wr_ack, a.arb_busy}), 64'd0);
        reset_n = 1'b1;
        tick();
        // reset during READ, RD_LAT=3
        b.rd_req = 1'b1; b.rd_addr = 18'h2;
        tick();
        tick();
        chk("rstr_pre", 64'({b.s1_OE, b.arb_busy}), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rstr_strobes", 64'({b.s1_OE, b.s1_WE}), 64'd3);
        chk("rstr_addr", 64'(b.s1_Addr), 64'h3ffff);
        chk("rstr_valid_busy_data", 64'({b.rd_valid, b.arb_busy, b.rd_data}), 64'd0);
        b.rd_req = 1'b0;
        tick();
        chk("rstr_no_valid", 64'(b.rd_valid), 64'd0);
        reset_n = 1'b1;
        tick();
        // normal write after reset, top address
        a.wr_req = 1'b1; a.wr_addr = 18'h3ffff; a.wr_wdata = 32'h0BAD_F00D;
        tick();
        chk("post_rst_wr", 64'({a.wr_ack, a.s1_WE, a.s1_Addr}), {44'h0, 1'b1, 1'b0, 18'h3ffff});
        chk("post_rst_wd", 64'(a.s1_WD), 64'h0BAD_F00D);
        a.wr_req = 1'b0;
        tick();
        tick();
        // back-to-back reads 0..3 on RD_LAT=3
        n = 0; cyc = 0; last = 0; upd = 1'b0;
        b.rd_req = 1'b1; b.rd_addr = 18'h0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            cyc++;
            if (upd) begin
                b.rd_addr = 18'(n);
                upd = 1'b0;
            end
            if (b.rd_valid) begin
                chk("b2b_data", 64'(b.rd_data), 64'(32'hDEAD_BEEF ^ 32'(n)));
                if (n > 0) chk("b2b_spacing", 64'(cyc - last), 64'd5);
                last = cyc;
                n++;
                upd = 1'b1;
            end
        end
        b.rd_req = 1'b0;
        chk("b2b_count", 64'(n), 64'd4);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single 32-bit capture SRAM port (s1) between two requesters: the pixel capture writer (write port) and the dump sequencer (read port).
- Produces all s1 strobes, address and write data, and sequences each access through a fixed-timing state machine.
- Write port has priority so that pixel data is not dropped. Read port is served when the write port is idle, or under the fairness option.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 32, SRAM data width.
- RD_LAT, 1, number of cycles s1_OE is held low before read data is captured. Legal range 1..15; 0 behaves as 1.
- MAX_WR_BURST, 8, consecutive write grants allowed while a read is pending. Used only with the fairness option.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_req  in  1  write request, level, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req=1
- wr_wdata  in  DATA_W  write data, stable while wr_req=1
- wr_ack  out  1  one-cycle pulse, write granted and strobed
- rd_req  in  1  read request, level, held until rd_valid
- rd_addr  in  ADDR_W  read address, stable while rd_req=1
- rd_data  out  DATA_W  read data, valid when rd_valid=1, held afterwards
- rd_valid  out  1  one-cycle pulse, read complete (also serves as the read acknowledge)
- arb_busy  out  1  high in every state except IDLE
- s1_Addr  out  ADDR_W  SRAM address
- s1_WD  out  DATA_W  SRAM write data
- s1_RD  in  DATA_W  SRAM read data
- s1_OE  out  1  SRAM output enable, active low
- s1_WE  out  1  SRAM write enable, active low

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset reset_n.
- Reset values: state=IDLE, s1_OE=1, s1_WE=1, s1_Addr=18'h3ffff, s1_WD=0, wr_ack=0, rd_valid=0, rd_data=0, arb_busy=0, read-latency counter=0, fairness counter=0. All outputs are registered.
- States: IDLE, WRITE, WREC, READ.
- IDLE: requests are sampled only in this state.
  - If wr_req=1 (and fairness does not force a read): s1_Addr<=wr_addr, s1_WD<=wr_wdata, s1_WE<=0, wr_ack<=1, go to WRITE.
  - Else if rd_req=1: s1_Addr<=rd_addr, s1_OE<=0, latency counter<=RD_LAT-1, go to READ.
  - Else stay in IDLE. s1_Addr and s1_WD hold their last value.
- WRITE: one cycle. s1_WE<=1, wr_ack<=0, go to WREC. Address and data hold, giving one cycle of hold after the WE rising edge.
- WREC: one recovery cycle, then go to IDLE. A write occupies 3 cycles from IDLE to IDLE.
- READ:
  - While counter!=0: decrement and keep s1_OE=0.
  - When counter==0: rd_data<=s1_RD, rd_valid<=1, s1_OE<=1, go to IDLE.
  - rd_valid is therefore high in the first IDLE cycle after the read. Read occupancy is RD_LAT+1 cycles.
- Simultaneous wr_req and rd_req in IDLE: write wins, unless fairness overrides.
- Requester handshake: a requester may drop or change its request in the cycle after wr_ack or rd_valid. No re-grant is possible before that cycle, because WREC and the IDLE sampling cycle intervene.
- A request deasserted mid-transaction is ignored; the access always completes.
- s1_OE and s1_WE are never low in the same cycle.
- Address 18'h3ffff is an ordinary address. No wrap or range checking is done here.
- Reset asserted mid-access: immediate return to the reset values. No ack or valid pulse is issued for the aborted access.
- arb_busy = (state != IDLE).

Optional Feature:
- Macro: SRAM_ARB_FAIRNESS_EN.
- When defined:
  - A 4-bit counter increments on each write grant made while rd_req=1.
  - It clears on a read grant, and on any IDLE cycle where rd_req=0.
  - When counter==MAX_WR_BURST and both requests are present, IDLE grants the read instead of the write.
- When not defined: strict write priority; the counter logic is absent.

Test Plan:
- Single write, wr_addr=18'h00010, wr_wdata=32'hA5A5_1234 → s1_WE low exactly 1 cycle with those values on s1_Addr/s1_WD; wr_ack 1 cycle; back in IDLE 3 cycles after the grant.
- Single read with RD_LAT=1 and then RD_LAT=3, s1_RD model returning 32'hDEAD_BEEF → s1_OE low for 1 cycle and 3 cycles respectively; rd_data=32'hDEAD_BEEF with rd_valid pulse in the following cycle.
- wr_req and rd_req raised in the same cycle → write completes first (wr_ack), then the read is granted at the next IDLE; OE and WE never overlap.
- Continuous wr_req with rd_req held, macro off → no rd_valid across 50 writes. Same stimulus with macro on and MAX_WR_BURST=8 → read granted after exactly 8 writes, then writes resume.
- reset_n pulled low during the WRITE state and again during READ with RD_LAT=3 → outputs return immediately to reset values (s1_Addr=18'h3ffff, strobes high), no ack/valid pulse; normal operation after release.
- Back-to-back reads at addresses 0..3 with the requester updating rd_addr the cycle after each rd_valid → 4 rd_valid pulses, data in address order, RD_LAT+2 cycles between pulses.
